// File: rtl/fetch_predecode_queue.sv
// rtl/fetch_predecode_queue.sv - single-outstanding instruction fetch with predecode, PC steering and dispatch queue
//
// Purpose:
//   Issues one word fetch at a time, predecodes the returned instruction
//   (B-type uses the predictor bit, JAL always taken), steers the next PC and
//   buffers {pc, inst, pred_taken, pred_idx} in a circular FIFO for dispatch.
//   A redirect clears the queue, reloads the PC and discards any in-flight word.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   mem_req_valid/addr/ready       fetch request handshake (word-aligned address)
//   mem_resp_valid/data            returned instruction (one-cycle pulse)
//   which_predictor, jump_in       predictor index pc[4:2] out, taken bit back
//   redirect_valid, redirect_pc    flush / mispredict restart
//   out_valid/ready, out_pc, out_inst, out_pred_taken, out_pred_idx
//                                  queue head towards dispatch
//
// Configuration:
//   FETCH_BYPASS_EN  when defined, a response arriving at an empty queue is
//                    presented on out_* in the same cycle and, if consumed,
//                    never written into the queue.

module fetch_predecode_queue #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic [2:0]  which_predictor,
   input  logic        jump_in,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_pred_taken,
   output logic [2:0]  out_pred_idx
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t         state, state_next;
   logic [31:0]    pc;
   logic [AW:0]    count;
   logic [AW-1:0]  rd_ptr, wr_ptr;

   logic [31:0]    q_pc    [DEPTH];
   logic [31:0]    q_inst  [DEPTH];
   logic           q_taken [DEPTH];
   logic [2:0]     q_idx   [DEPTH];

   logic [6:0]     opcode;
   logic           is_b, is_jal;
   logic [31:0]    imm_b, imm_j;
   logic           pd_taken;
   logic [31:0]    pd_next;
   logic           resp_take, empty, bypass, push, pop, handshake;

   // Predecode of the returned word. While a request is outstanding pc still
   // holds the address of that request, so pc is the instruction's own PC.
   assign opcode   = mem_resp_data[6:0];
   assign is_b     = (opcode == 7'b1100011);
   assign is_jal   = (opcode == 7'b1101111);
   assign imm_b    = {{19{mem_resp_data[31]}}, mem_resp_data[31], mem_resp_data[7],
                      mem_resp_data[30:25], mem_resp_data[11:8], 1'b0};
   assign imm_j    = {{11{mem_resp_data[31]}}, mem_resp_data[31], mem_resp_data[19:12],
                      mem_resp_data[20], mem_resp_data[30:21], 1'b0};
   assign pd_taken = is_jal | (is_b & jump_in);
   assign pd_next  = is_jal             ? pc + imm_j :
                     (is_b & jump_in)   ? pc + imm_b : pc + 32'd4;

   assign which_predictor = pc[4:2];

   assign empty     = (count == '0);
   assign resp_take = (state == REQ) && mem_resp_valid && !redirect_valid;
`ifdef FETCH_BYPASS_EN
   assign bypass    = resp_take && empty;
`else
   assign bypass    = 1'b0;
`endif

   assign mem_req_valid = !rst && (state == IDLE) && (count < (AW+1)'(DEPTH));
   assign mem_req_addr  = mem_req_valid ? pc : 32'h0;
   assign handshake     = mem_req_valid && mem_req_ready;

   assign out_valid      = !empty || bypass;
   assign out_pc         = !empty ? q_pc[rd_ptr]    : bypass ? pc       : 32'h0;
   assign out_inst       = !empty ? q_inst[rd_ptr]  : bypass ? mem_resp_data : 32'h0;
   assign out_pred_taken = !empty ? q_taken[rd_ptr] : bypass & pd_taken;
   assign out_pred_idx   = !empty ? q_idx[rd_ptr]   : bypass ? pc[4:2]  : 3'd0;

   // A bypassed word that dispatch takes right away never occupies a slot.
   assign pop  = !empty && out_ready && !redirect_valid;
   assign push = resp_take && !(bypass && out_ready);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (handshake)      state_next = REQ;
         REQ:     if (mem_resp_valid) state_next = IDLE;
         DROP:    if (mem_resp_valid) state_next = IDLE;
         default:                     state_next = IDLE;
      endcase
      // Any response still in flight after a redirect must be swallowed,
      // including one whose request is being accepted this very cycle.
      if (redirect_valid) begin
         if ((((state == REQ) || (state == DROP)) && !mem_resp_valid) || handshake)
            state_next = DROP;
         else
            state_next = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         state <= state_next;
         if (redirect_valid) begin
            pc     <= redirect_pc;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (resp_take) pc <= pd_next;
            if (push)      wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   // Entry storage needs no reset: out_* are gated by count.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]    <= pc;
         q_inst[wr_ptr]  <= mem_resp_data;
         q_taken[wr_ptr] <= pd_taken;
         q_idx[wr_ptr]   <= pc[4:2];
      end
   end

endmodule

// File: tb/tb_fetch_predecode_queue.sv
// tb/tb_fetch_predecode_queue.sv - randomized bench with behavioural fetch/queue model and literal pins
module tb_fetch_predecode_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic [2:0]  which_predictor;
   logic        jump_in;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_pred_taken;
   logic [2:0]  out_pred_idx;

   fetch_predecode_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .which_predictor(which_predictor), .jump_in(jump_in),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .out_pred_taken(out_pred_taken), .out_pred_idx(out_pred_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        taken;
      logic [2:0]  idx;
      logic [31:0] nxt;
   } ent_t;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   ent_t        m_q[$];
   logic [31:0] m_pc;
   bit          outstanding, discard;

   // bench memory
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;

   // stimulus controls
   bit          simple_prog;
   int          rdy_pct, ordy_pct, redir_pct, max_delay;
   logic [31:0] seed;
   int          hs_cnt;
   logic [31:0] last_hs_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_b(input int imm);
      logic [12:0] v;
      v = imm[12:0];
      return {v[12], v[10:5], 5'd0, 5'd0, 3'b000, v[4:1], v[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input int imm);
      logic [20:0] v;
      v = imm[20:0];
      return {v[20], v[10:1], v[11], v[19:12], 5'd0, 7'b1101111};
   endfunction

   // Instruction semantics from the ISA description: branch offsets in bytes.
   function automatic ent_t predecode(input logic [31:0] pc, input logic [31:0] inst, input logic jin);
      ent_t e;
      int   ib, ij;
      ib = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      ij = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      e.pc   = pc;
      e.inst = inst;
      e.idx  = pc[4:2];
      if (inst[6:0] == 7'b1101111) begin
         e.taken = 1'b1;
         e.nxt   = pc + ij;
      end else if (inst[6:0] == 7'b1100011 && jin) begin
         e.taken = 1'b1;
         e.nxt   = pc + ib;
      end else begin
         e.taken = 1'b0;
         e.nxt   = pc + 32'd4;
      end
      return e;
   endfunction

   function automatic logic [31:0] prog(input logic [31:0] addr);
      logic [31:0] h;
      int          imm;
      if (simple_prog) return 32'h00100093;
      h   = (addr * 32'h9E3779B1) ^ seed;
      imm = (int'(h[7:3]) - 16) * 4;
      case (h[30:29])
         2'd0:    return 32'h00100093;
         2'd1:    return enc_b(imm);
         2'd2:    return enc_j(imm);
         default: return 32'h00008067;
      endcase
   endfunction

   task automatic step();
      bit   exp_rv, exp_ov, hs, dut_hs;
      ent_t head, pd;
      bit   use_bypass;
      @(negedge clk);
      mem_resp_valid = mem_busy && (mem_cnt == 1);
      mem_resp_data  = mem_resp_valid ? prog(mem_addr) : 32'($urandom);
      mem_req_ready  = ($urandom_range(0, 99) < rdy_pct);
      out_ready      = ($urandom_range(0, 99) < ordy_pct);
      jump_in        = $urandom_range(0, 1);
      redirect_valid = ($urandom_range(0, 999) < redir_pct * 10);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + ($urandom_range(0, 3) * 4)
                                                   : ($urandom & 32'h0000_03FC);
      #1;
      // expected outputs
      exp_rv = !outstanding && (m_q.size() < DEPTH);
      pd = predecode(m_pc, mem_resp_data, jump_in);
      use_bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
      use_bypass = (m_q.size() == 0) && outstanding && !discard && mem_resp_valid && !redirect_valid;
`endif
      exp_ov = (m_q.size() > 0) || use_bypass;
      if (m_q.size() > 0) head = m_q[0];
      else                head = pd;

      chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("mem_req_addr", mem_req_addr, m_pc);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
         chk("out_pc", out_pc, head.pc);
         chk("out_inst", out_inst, head.inst);
         chk("out_pred_taken", 32'(out_pred_taken), 32'(head.taken));
         chk("out_pred_idx", 32'(out_pred_idx), 32'(head.idx));
      end
      if (outstanding && !discard && mem_resp_valid)
         chk("which_predictor", 32'(which_predictor), 32'(m_pc[4:2]));

      // memory observes the DUT's request (stimulus side only)
      dut_hs = mem_req_valid && mem_req_ready;
      if (mem_resp_valid) mem_busy = 1'b0;
      else if (mem_busy)  mem_cnt--;
      if (dut_hs) begin
         mem_busy = 1'b1;
         mem_cnt  = $urandom_range(1, max_delay);
         mem_addr = mem_req_addr;
         hs_cnt++;
         last_hs_addr = mem_req_addr;
      end

      // model update
      hs = exp_rv && mem_req_ready;
      if (redirect_valid) begin
         m_q.delete();
         m_pc = redirect_pc;
         if (outstanding && !mem_resp_valid) discard = 1'b1;
         else if (hs) begin outstanding = 1'b1; discard = 1'b1; end
         else begin outstanding = 1'b0; discard = 1'b0; end
      end else begin
         if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
         if (outstanding && mem_resp_valid) begin
            if (!discard) begin
               if (!(use_bypass && out_ready)) m_q.push_back(pd);
               m_pc = pd.nxt;
            end
            outstanding = 1'b0;
            discard     = 1'b0;
         end
         if (hs) begin outstanding = 1'b1; discard = 1'b0; end
      end
   endtask

   ent_t p;

   initial begin
      rst = 1'b1;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; jump_in = 0;
      redirect_valid = 0; redirect_pc = 0; out_ready = 0;
      seed = $urandom;

      // literal pins of the model's decode and encoders
      chk("enc_b(+16)", enc_b(16), 32'h00000863);
      chk("enc_j(-8)", enc_j(-8), 32'hFF9FF06F);
      p = predecode(32'h20, 32'h00000863, 1'b1);
      chk("beq_taken_next", p.nxt, 32'h30);
      chk("beq_taken_bit", 32'(p.taken), 32'h1);
      chk("beq_idx", 32'(p.idx), 32'h0);
      p = predecode(32'h20, 32'h00000863, 1'b0);
      chk("beq_not_taken_next", p.nxt, 32'h24);
      p = predecode(32'h40, 32'hFF9FF06F, 1'b0);
      chk("jal_next", p.nxt, 32'h38);
      chk("jal_taken", 32'(p.taken), 32'h1);
      p = predecode(32'h40, 32'h00008067, 1'b1);
      chk("jalr_next", p.nxt, 32'h44);

      // reset state
      @(negedge clk); #1;
      chk("reset_mem_req_valid", 32'(mem_req_valid), 32'h0);
      chk("reset_mem_req_addr", mem_req_addr, 32'h0);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_out_pc", out_pc, 32'h0);
      rst = 1'b0;
      m_pc = 32'h0; outstanding = 0; discard = 0; mem_busy = 0; mem_cnt = 0; mem_addr = 0;
      hs_cnt = 0; last_hs_addr = 0;

      // fill: sequential addi, dispatch stalled -> exactly DEPTH requests
      simple_prog = 1; rdy_pct = 100; ordy_pct = 0; redir_pct = 0; max_delay = 1;
      repeat (40) step();
      chk("fill_request_count", 32'(hs_cnt), 32'(DEPTH));
      chk("fill_head_pc", out_pc, 32'h0);
      ordy_pct = 100;
      step();
      ordy_pct = 0;
      repeat (30) step();
      chk("refill_request_count", 32'(hs_cnt), 32'(DEPTH + 1));
      chk("refill_last_addr", last_hs_addr, 32'h20);
      chk("refill_head_pc", out_pc, 32'h4);

      // randomized traffic with redirects, varying backpressure and latency
      simple_prog = 0; max_delay = 3;
      for (int blk = 0; blk < 15; blk++) begin
         rdy_pct   = $urandom_range(40, 100);
         ordy_pct  = (blk % 3 == 0) ? 10 : (blk % 3 == 1) ? 50 : 90;
         redir_pct = (blk % 2 == 0) ? 2 : 6;
         repeat (200) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
